// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 S-box controller.
package rc4_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StRdA,
        StRdB,
        StWrA,
        StWrB,
        StRdFin
    } state_e;

    localparam logic OP_READ = 1'b0;
    localparam logic OP_SWAP = 1'b1;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned SBOX_DEPTH = 256;

endpackage

// File: rtl/sbox_ram.sv
// Single-port S-box RAM: 1-cycle synchronous read (read-first), write at the clock edge.
module sbox_ram #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] wdata,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/rc4_sbox_ctrl.sv
// RC4 S-box controller: identity init, then arbitrated read/swap transactions on a shared RAM.
// Define RC4_SBOX_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module rc4_sbox_ctrl
    import rc4_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reinit,
    output logic                  init_done,
    output logic                  busy,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_op,
    input  logic [NUM_REQ*AW-1:0] req_addr_a,
    input  logic [NUM_REQ*AW-1:0] req_addr_b,
    output logic [NUM_REQ-1:0]    ack,
    output logic [AW-1:0]         rdata_a,
    output logic [AW-1:0]         rdata_b
);

    state_e        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic          init_done_q, init_done_d;
    logic          op_q, op_d;
    logic          grant_q, grant_d;
    logic [AW-1:0] addr_a_q, addr_a_d;
    logic [AW-1:0] addr_b_q, addr_b_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] b_q, b_d;
    logic [AW-1:0] out_a_q, out_a_d;
    logic [AW-1:0] out_b_q, out_b_d;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [AW-1:0] ram_wdata;
    logic [AW-1:0] ram_rdata;

    logic          any_req;
    logic          gnt_idx;
    logic          ack_valid;
    logic [AW-1:0] cur_b;

    // Arbiter: gnt_idx is only meaningful when any_req is set.
`ifdef RC4_SBOX_RR_EN
    logic last_q, last_d;

    always_comb begin
        any_req = |req;
        if (&req) begin
            gnt_idx = ~last_q;
        end else begin
            gnt_idx = ~req[0];
        end
    end
`else
    always_comb begin
        any_req = |req;
        gnt_idx = ~req[0];
    end
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        init_done_d = init_done_q;
        op_d        = op_q;
        grant_d     = grant_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        a_d         = a_q;
        b_d         = b_q;
        ram_we      = 1'b0;
        ram_addr    = addr_a_q;
        ram_wdata   = a_q;
        ack_valid   = 1'b0;
        cur_b       = b_q;
`ifdef RC4_SBOX_RR_EN
        last_d      = last_q;
`endif

        unique case (state_q)
            StInit: begin
                ram_we    = 1'b1;
                ram_addr  = k_q;
                ram_wdata = k_q;
                if (k_q == '1) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StIdle: begin
                if (reinit) begin
                    state_d     = StInit;
                    init_done_d = 1'b0;
                    k_d         = '0;
                end else if (any_req) begin
                    grant_d  = gnt_idx;
                    op_d     = req_op[gnt_idx];
                    addr_a_d = gnt_idx ? req_addr_a[2*AW-1:AW] : req_addr_a[AW-1:0];
                    addr_b_d = gnt_idx ? req_addr_b[2*AW-1:AW] : req_addr_b[AW-1:0];
`ifdef RC4_SBOX_RR_EN
                    last_d   = gnt_idx;
`endif
                    state_d  = StRdA;
                end
            end
            StRdA: begin
                ram_addr = addr_a_q;
                state_d  = StRdB;
            end
            StRdB: begin
                ram_addr = addr_b_q;
                a_d      = ram_rdata;
                state_d  = (op_q == OP_SWAP) ? StWrA : StRdFin;
            end
            StWrA: begin
                ram_addr  = addr_a_q;
                ram_we    = 1'b1;
                ram_wdata = ram_rdata;
                b_d       = ram_rdata;
                state_d   = StWrB;
            end
            StWrB: begin
                ram_addr  = addr_b_q;
                ram_we    = 1'b1;
                ram_wdata = a_q;
                ack_valid = 1'b1;
                state_d   = StIdle;
            end
            StRdFin: begin
                // S[b] arrives from the RAM this cycle; expose it during the ack.
                b_d       = ram_rdata;
                cur_b     = ram_rdata;
                ack_valid = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_comb begin
        ack = '0;
        if (ack_valid) begin
            ack[grant_q] = 1'b1;
        end
        out_a_d = ack_valid ? a_q : out_a_q;
        out_b_d = ack_valid ? cur_b : out_b_q;
    end

    assign rdata_a   = out_a_d;
    assign rdata_b   = out_b_d;
    assign init_done = init_done_q;
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StInit;
            k_q         <= '0;
            init_done_q <= 1'b0;
            op_q        <= OP_READ;
            grant_q     <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            init_done_q <= init_done_d;
            op_q        <= op_d;
            grant_q     <= grant_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

`ifdef RC4_SBOX_RR_EN
    // Resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    sbox_ram #(
        .AW (AW)
    ) u_sbox_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_rc4_sbox_ctrl.sv
// Directed bench for rc4_sbox_ctrl with an S-box model and an expected-ack scoreboard.
module tb_rc4_sbox_ctrl;
    import rc4_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reinit = 1'b0;
    logic        init_done;
    logic        busy;
    logic [1:0]  req = '0;
    logic [1:0]  req_op = '0;
    logic [15:0] req_addr_a = '0;
    logic [15:0] req_addr_b = '0;
    logic [1:0]  ack;
    logic [7:0]  rdata_a;
    logic [7:0]  rdata_b;

    rc4_sbox_ctrl #(
        .AW (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reinit     (reinit),
        .init_done  (init_done),
        .busy       (busy),
        .req        (req),
        .req_op     (req_op),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .ack        (ack),
        .rdata_a    (rdata_a),
        .rdata_b    (rdata_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         r;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] s_model [256];
    logic [7:0] last_a = '0;
    logic [7:0] last_b = '0;
    int         checks = 0;
    int         errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_identity();
        for (int i = 0; i < 256; i++) s_model[i] = 8'(i);
    endtask

    task automatic set_req(input int r, input logic op, input logic [7:0] a, input logic [7:0] b);
        req[r]            = 1'b1;
        req_op[r]         = op;
        req_addr_a[r*8+:8] = a;
        req_addr_b[r*8+:8] = b;
    endtask

    task automatic push_exp(input int r, input logic op, input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [7:0] t;
        e.r = r;
        e.a = s_model[a];
        e.b = s_model[b];
        if (op == OP_SWAP) begin
            t          = s_model[a];
            s_model[a] = s_model[b];
            s_model[b] = t;
        end
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string tag, input int lat_exp, input int bound);
        int   n = 0;
        exp_t e;
        do begin
            tick();
            n++;
        end while (ack == 2'b00 && n < bound);
        check({tag, "_ack_seen"}, 32'(ack != 2'b00), 1);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (ack != 2'b00) begin
                check({tag, "_ack_onehot"}, 32'(ack), 32'(1 << e.r));
                check({tag, "_rdata_a"}, 32'(rdata_a), 32'(e.a));
                check({tag, "_rdata_b"}, 32'(rdata_b), 32'(e.b));
                check({tag, "_latency"}, 32'(n), 32'(lat_exp));
                last_a = e.a;
                last_b = e.b;
            end
        end
    endtask

    // Runs one transaction from IDLE and checks the single-cycle ack and held rdata.
    task automatic do_txn(input string tag, input int r, input logic op,
                          input logic [7:0] a, input logic [7:0] b);
        check({tag, "_idle_before"}, 32'(busy), 0);
        set_req(r, op, a, b);
        push_exp(r, op, a, b);
        wait_ack(tag, (op == OP_SWAP) ? 4 : 3, 20);
        req[r] = 1'b0;
        tick();
        check({tag, "_ack_pulse"}, 32'(ack), 0);
        check({tag, "_hold_a"}, 32'(rdata_a), 32'(last_a));
        check({tag, "_hold_b"}, 32'(rdata_b), 32'(last_b));
    endtask

    task automatic wait_init(input string tag);
        for (int i = 1; i <= 256; i++) begin
            tick();
            check({tag, "_no_ack"}, 32'(ack), 0);
            if (i == 255) check({tag, "_done_255"}, 32'(init_done), 0);
            if (i == 256) check({tag, "_done_256"}, 32'(init_done), 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_identity();
        #2;
        check("rst_init_done", 32'(init_done), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_ack", 32'(ack), 0);
        check("rst_rdata_a", 32'(rdata_a), 0);
        check("rst_rdata_b", 32'(rdata_b), 0);
        tick();
        rst = 1'b0;

        // Request raised during INIT is held off until identity init completes.
        set_req(0, OP_READ, 8'h05, 8'hFA);
        push_exp(0, OP_READ, 8'h05, 8'hFA);
        wait_init("init");
        check("init_busy", 32'(busy), 0);
        wait_ack("read_init", 3, 20);
        req[0] = 1'b0;
        tick();
        check("read_init_pulse", 32'(ack), 0);

        do_txn("swap_3_10", 0, OP_SWAP, 8'h03, 8'h10);
        do_txn("read_3_10", 0, OP_READ, 8'h03, 8'h10);
        do_txn("swap_7f_7f", 1, OP_SWAP, 8'h7F, 8'h7F);
        do_txn("read_7f", 1, OP_READ, 8'h7F, 8'h7F);

        // Both requesters hold SWAP requests for four grants.
        for (int i = 0; i < 4; i++) begin
`ifdef RC4_SBOX_RR_EN
            if (i % 2 == 0) push_exp(0, OP_SWAP, 8'h20, 8'h21);
            else            push_exp(1, OP_SWAP, 8'h30, 8'h31);
`else
            push_exp(0, OP_SWAP, 8'h20, 8'h21);
`endif
        end
        set_req(0, OP_SWAP, 8'h20, 8'h21);
        set_req(1, OP_SWAP, 8'h30, 8'h31);
        for (int i = 0; i < 4; i++) begin
            wait_ack($sformatf("arb%0d", i), (i == 0) ? 4 : 5, 20);
        end
        req = 2'b00;
        tick();
        check("arb_end_ack", 32'(ack), 0);

        // reinit in IDLE restarts identity init; a request in the window waits.
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        check("reinit_done_low", 32'(init_done), 0);
        check("reinit_busy", 32'(busy), 1);
        model_identity();
        set_req(0, OP_READ, 8'h03, 8'h10);
        push_exp(0, OP_READ, 8'h03, 8'h10);
        wait_init("reinit");
        wait_ack("reinit_read", 3, 20);
        req[0] = 1'b0;
        tick();

        do_txn("swap_40_41", 0, OP_SWAP, 8'h40, 8'h41);

        // rst asserted while the SWAP is in WR_A aborts it without an ack.
        set_req(0, OP_SWAP, 8'h40, 8'h41);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_ack", 32'(ack), 0);
        end
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 1);
        check("abort_ack", 32'(ack), 0);
        check("abort_init_done", 32'(init_done), 0);
        check("abort_rdata_a", 32'(rdata_a), 0);
        req = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        model_identity();
        wait_init("rerun");

        do_txn("post_rst_40_41", 0, OP_READ, 8'h40, 8'h41);
        do_txn("post_rst_3_10", 1, OP_READ, 8'h03, 8'h10);
        do_txn("post_rst_5_fa", 0, OP_READ, 8'h05, 8'hFA);

        check("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc4_sbox_ctrl.md
# rc4_sbox_ctrl

Controller for the shared 256-entry RC4 S-box memory. It initialises S to the identity permutation, then arbitrates read and swap transactions from two requesters: requester 0 is key scheduling, requester 1 is keystream generation. Each granted transaction runs as a fixed read/read/write/write sequence on a single-port synchronous RAM, so requesters never touch the memory directly.

## Interface
Parameters:
- AW, 8, S-box address width; depth is 2**AW; data width equals AW

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- reinit  in  1  level; sampled only in IDLE; restarts identity initialisation
- init_done  out  1  high once S holds the identity permutation; cleared by rst/reinit
- busy  out  1  high in any state other than IDLE
- req  in  2  per-requester transaction request
- req_op  in  2  per-requester op: 0 = READ, 1 = SWAP
- req_addr_a  in  2×AW  per-requester address a (i index)
- req_addr_b  in  2×AW  per-requester address b (j index)
- ack  out  2  one-cycle completion pulse, one-hot
- rdata_a  out  AW  pre-transaction S[a], valid while ack is high
- rdata_b  out  AW  pre-transaction S[b], valid while ack is high

## Operation
- States: INIT, IDLE, RD_A, RD_B, WR_A, WR_B, RD_FIN.
- INIT: counter k runs 0..255 and writes S[k]=k, one write per cycle. After the write of k=255, go to IDLE and set init_done.
- IDLE, priority order:
  - reinit: go to INIT, clear init_done, reset k to 0.
  - any req: grant one requester, latch its op, addr_a and addr_b, go to RD_A.
- RD_A: RAM address = a.
- RD_B: RAM address = b; capture RAM dout into the a register.
- If op = SWAP:
  - WR_A: write S[a] = RAM dout (S[b]); capture it into the b register.
  - WR_B: write S[b] = a register; pulse ack[g]; go to IDLE.
- If op = READ:
  - RD_FIN: capture b; pulse ack[g]; go to IDLE.
- a == b on SWAP: both writes store the same value, so S is unchanged. No special case is needed.
- Requesters hold req, op and addresses until ack. Addresses are latched at grant, so later changes are ignored.
- If req is still high in the cycle after ack, it is a new request.
- req during INIT or during a transaction is held off: no ack until the request is granted.
- rdata_a and rdata_b hold their last values between acks.

## Timing
- Reset values: init_done=0, busy=1, ack=0, rdata_a=0, rdata_b=0. State = INIT with k=0.
- rst asserted mid-transaction: the transaction is aborted with no ack, and INIT reruns in full.
- Initialisation takes 256 cycles. init_done rises on the 256th rising edge after rst deassertion.
- Request granted at edge c:
  - SWAP: ack is high in cycle c+4.
  - READ: ack is high in cycle c+3.
  - Back in IDLE one cycle after the ack. The next grant is possible at that IDLE edge.
- Sustained throughput: one SWAP per 5 cycles.
- RAM: single port, 1-cycle synchronous read, write takes effect at the clock edge.
- Address arithmetic is mod 256 and belongs to the requesters. The controller performs no arithmetic except k+1, which stops at 255 and never wraps.

## Configuration
- RC4_SBOX_RR_EN defined: round-robin arbitration.
  - A last-grant pointer resets to 1, so requester 0 wins the first tie.
  - On a tie, the requester that was not granted last wins.
- RC4_SBOX_RR_EN undefined: fixed priority. Requester 0 always wins a tie.

## Structure
- Package rc4_pkg holds:
  - the state enum
  - the op encodings OP_READ=1'b0 and OP_SWAP=1'b1
  - NUM_REQ=2
  - SBOX_DEPTH=256
- Sub-module sbox_ram: 256×8 single-port synchronous-read RAM. Ports: clk, we, addr, wdata, rdata.
- The arbiter is inline combinational logic. It is not a separate module.

## Test plan
- Release rst, then issue requester 0 READ a=0x05, b=0xFA -> init_done rises at edge 256; ack[0] at c+3 with rdata_a=0x05, rdata_b=0xFA.
- Requester 0 SWAP 0x03/0x10, then READ 0x03/0x10 -> swap ack at c+4 with rdata 0x03/0x10; read returns 0x10/0x03.
- Requester 1 SWAP a=b=0x7F, then READ 0x7F -> returns 0x7F.
- req=2'b11 held, both SWAP -> RR build: grants 0, 1, 0, 1; fixed build: requester 0 every time while it holds req.
- After several swaps, assert reinit in IDLE -> init_done drops for 256 cycles; a req raised in that window gets no ack; afterwards READ 0x03/0x10 returns 0x03/0x10.
- Assert rst during WR_A of a SWAP -> no ack; busy=1; S is the identity again once init_done rises.
